// File: rtl/axi_split_modify_pkg.sv
// Shared definitions for the axi_split_modify splitter: mode encodings
// (shared with the software register map) and the packet-latch FSM states.
package axi_split_modify_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_NEGATE = 2'd2;
  localparam logic [1:0] MODE_ZERO   = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/axi_split_modify_port.sv
// One output lane of the splitter: applies the data modification on write,
// buffers beats in a 2-entry FIFO and counts completed packets.
module axi_split_modify_port
  import axi_split_modify_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  output logic             o_full,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam int HALF_W = WIDTH / 2;

  // Two's-complement negate of one half; the most-negative value has no
  // positive counterpart and saturates to the most-positive value.
  function automatic logic signed [HALF_W-1:0] sat_neg(input logic signed [HALF_W-1:0] v);
    logic signed [HALF_W-1:0] most_neg;
    most_neg = {1'b1, {(HALF_W-1){1'b0}}};
    if (v == most_neg) sat_neg = ~most_neg;
    else               sat_neg = -v;
  endfunction

  function automatic logic [WIDTH-1:0] modify(input logic [1:0] m, input logic [WIDTH-1:0] d);
    case (m)
      MODE_PASS:   modify = d;
      MODE_INVERT: modify = ~d;
      MODE_NEGATE: modify = {sat_neg($signed(d[WIDTH-1:HALF_W])), sat_neg($signed(d[HALF_W-1:0]))};
      default:     modify = '0;
    endcase
  endfunction

  logic [WIDTH-1:0] r_data [2];
  logic             r_last [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             w_wr;
  logic             w_rd;

  // A full FIFO refuses writes; a pop frees its slot only on the next cycle.
  assign o_full   = (r_count == 2'd2);
  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_data[r_rptr];
  assign o_tlast  = r_last[r_rptr];
  assign w_wr     = i_wr & ~o_full;
  assign w_rd     = o_tvalid & i_tready;
  assign o_pkt_cnt = r_pkt_cnt;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_wr) r_wptr <= ~r_wptr;
      if (w_rd) r_rptr <= ~r_rptr;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, modification applied as the beat is written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wptr] <= modify(i_mode, i_tdata);
      r_last[r_wptr] <= i_tlast;
    end
  end

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                   r_pkt_cnt <= '0;
    else if (w_rd && o_tlast)    r_pkt_cnt <= r_pkt_cnt + 1'b1;
  end

endmodule

// File: rtl/axi_split_modify.sv
// 1-to-NUM_PORTS AXI-stream splitter with per-port modification and enable.
// Mode/enable are latched at packet start; each port has its own FIFO.
module axi_split_modify
  import axi_split_modify_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*NUM_PORTS-1:0]     mode,
  input  logic [NUM_PORTS-1:0]       enable,
  input  logic [WIDTH-1:0]           i_tdata,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic [WIDTH*NUM_PORTS-1:0] o_tdata,
  output logic [NUM_PORTS-1:0]       o_tlast,
  output logic [NUM_PORTS-1:0]       o_tvalid,
  input  logic [NUM_PORTS-1:0]       o_tready,
  output logic [CNT_W*NUM_PORTS-1:0] pkt_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2*NUM_PORTS-1:0] r_act_mode;
  logic [NUM_PORTS-1:0]   r_act_en;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [2*NUM_PORTS-1:0] w_mode_set;
  logic [NUM_PORTS-1:0]   w_en_set;
  logic [NUM_PORTS-1:0]   w_full;
  logic                   w_ready;
  logic                   w_acc;
  logic                   w_latch;

  // The beat that opens a packet uses the live inputs; later beats use the latched copy.
  always_comb begin
    w_en_set   = enable;
    w_mode_set = mode;
    if (r_state == ST_ACTIVE) begin
      w_en_set   = r_act_en;
      w_mode_set = r_act_mode;
    end
  end

  // Disabled ports never stall; independent of i_tvalid.
  assign w_ready  = ~reset & (&(~w_en_set | ~w_full));
  assign i_tready = w_ready;
  assign w_acc    = i_tvalid & w_ready;
  assign drop_cnt = r_drop_cnt;

  // Packet-latch FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_latch = 1'b1;
          if (!i_tlast) w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_acc && i_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register and mode/enable latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_act_mode <= '0;
      r_act_en   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_act_mode <= mode;
        r_act_en   <= enable;
      end
    end
  end

  // Count packets that ended with every port disabled.
  always_ff @(posedge clk) begin
    if (reset)                                  r_drop_cnt <= '0;
    else if (w_acc && i_tlast && w_en_set == '0) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    axi_split_modify_port #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .i_wr     (w_acc & w_en_set[g]),
      .i_mode   (w_mode_set[2*g +: 2]),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .o_full   (w_full[g]),
      .o_tdata  (o_tdata[WIDTH*g +: WIDTH]),
      .o_tlast  (o_tlast[g]),
      .o_tvalid (o_tvalid[g]),
      .i_tready (o_tready[g]),
      .o_pkt_cnt(pkt_cnt[CNT_W*g +: CNT_W])
    );
  end

endmodule
